lut3_cfg_ctrl: RTL and testbench

- Configuration sequencer for the 3-input serial-load LUT (8-entry truth table, serial config port en/S, select A/B/C, output z).
- Accepts an 8-bit truth table over a valid/ready handshake and serialises it into the LUT's shift port.
- Can then sweep all 8 select codes and compare z against the table, reporting pass/fail and a per-entry mismatch mask.
- When idle, passes user select inputs straight through, so the LUT operates as normal logic.

---
 rtl/lut3_cfg_ctrl.sv | 166 ++++++++++++++++
 tb/tb_lut3_cfg_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lut3_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lut3_cfg_ctrl
// Purpose  : Configuration sequencer for a 3-input serial-load LUT. Accepts an
//            8-bit truth table over valid/ready, shifts it into the LUT config
//            port, optionally sweeps all 8 select codes comparing z against
//            the table, and passes user selects through while idle.
// Ports    : clk, rst_n              - clock, async active-low reset
//            cfg_valid/ready/data   - truth-table load handshake
//            verify_en              - run readback verify after the load
//            usr_a/b/c              - user selects (used only in IDLE)
//            lut_en/s/a/b/c, lut_z  - LUT config / select / output
//            busy, done, pass       - status
//            mismatch[7:0]          - per-entry verify failure mask
// Revision : 1.0  initial release
// ============================================================================
module lut3_cfg_ctrl #(
  parameter int MSB_FIRST = 1,
  parameter int RD_LAT    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_data,
  input  logic       verify_en,
  input  logic       usr_a,
  input  logic       usr_b,
  input  logic       usr_c,
  output logic       lut_en,
  output logic       lut_s,
  output logic       lut_a,
  output logic       lut_b,
  output logic       lut_c,
  input  logic       lut_z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] mismatch
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_shift  = 2'd1;
  localparam logic [1:0] c_verify = 2'd2;
  localparam logic [1:0] c_done   = 2'd3;

  localparam logic [1:0] c_rd_lat = RD_LAT[1:0];

  logic [1:0] r_state;
  logic [2:0] r_cnt;
  logic [1:0] r_lat;
  logic [2:0] r_sel;
  logic [7:0] r_table;
  logic       r_verify;
  logic       r_en;
  logic       r_s;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [7:0] r_mismatch;
  logic [7:0] w_mm_next;
  logic       w_idle;

  // Table bit shifted out at shift position n.
  function automatic logic [2:0] f_pos(input logic [2:0] n);
    return (MSB_FIRST != 0) ? (3'd7 - n) : n;
  endfunction

  // Mismatch mask including the sample taken this cycle, so the final entry
  // is already reflected in pass when DONE is entered.
  always_comb begin
    w_mm_next        = r_mismatch;
    w_mm_next[r_sel] = (lut_z != r_table[r_sel]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_idle;
      r_cnt      <= 3'd0;
      r_lat      <= 2'd0;
      r_sel      <= 3'd0;
      r_table    <= 8'd0;
      r_verify   <= 1'b0;
      r_en       <= 1'b0;
      r_s        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_mismatch <= 8'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_idle: begin
          if (cfg_valid) begin
            r_table    <= cfg_data;
            r_verify   <= verify_en;
            r_pass     <= 1'b0;
            r_mismatch <= 8'd0;
            r_cnt      <= 3'd0;
            r_sel      <= 3'd0;
            r_en       <= 1'b1;
            // First serial bit must be on lut_s in the first SHIFT cycle.
            r_s        <= cfg_data[f_pos(3'd0)];
            r_busy     <= 1'b1;
            r_state    <= c_shift;
          end
        end
        c_shift: begin
          if (r_cnt == 3'd7) begin
            r_en  <= 1'b0;
            r_s   <= 1'b0;
            r_cnt <= 3'd0;
            if (r_verify) begin
              r_sel   <= 3'd0;
              r_lat   <= 2'd0;
              r_state <= c_verify;
            end else begin
              r_done     <= 1'b1;
              r_pass     <= 1'b1;
              r_mismatch <= 8'd0;
              r_state    <= c_done;
            end
          end else begin
            r_cnt <= r_cnt + 3'd1;
            r_s   <= r_table[f_pos(r_cnt + 3'd1)];
          end
        end
        c_verify: begin
          if (r_lat == c_rd_lat) begin
            r_mismatch <= w_mm_next;
            r_lat      <= 2'd0;
            if (r_sel == 3'd7) begin
              r_done  <= 1'b1;
              r_pass  <= (w_mm_next == 8'd0);
              r_sel   <= 3'd0;
              r_state <= c_done;
            end else begin
              r_sel <= r_sel + 3'd1;
            end
          end else begin
            r_lat <= r_lat + 2'd1;
          end
        end
        c_done: begin
          r_busy  <= 1'b0;
          r_state <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign w_idle    = (r_state == c_idle);
  assign cfg_ready = w_idle;
  assign lut_en    = r_en;
  assign lut_s     = r_s;
  assign lut_a     = w_idle ? usr_a : r_sel[2];
  assign lut_b     = w_idle ? usr_b : r_sel[1];
  assign lut_c     = w_idle ? usr_c : r_sel[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign mismatch  = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_lut3_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut3_cfg_ctrl
// Purpose  : Self-checking bench for lut3_cfg_ctrl with a behavioural
//            serial-load LUT and fault injection on the LUT output.
// Revision : 1.0  initial release
// ============================================================================
module tb_lut3_cfg_ctrl;

  localparam int MSB_FIRST = 1;
  localparam int RD_LAT    = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;
  logic       verify_en;
  logic       usr_a, usr_b, usr_c;
  logic       lut_en, lut_s, lut_a, lut_b, lut_c, lut_z;
  logic       busy, done, pass;
  logic [7:0] mismatch;

  logic [7:0] lut_mem = 8'd0;
  logic [7:0] fault   = 8'd0;
  logic [7:0] tbl     = 8'd0;
  int         acc_cnt = 0;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  lut3_cfg_ctrl #(.MSB_FIRST(MSB_FIRST), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .verify_en(verify_en),
    .usr_a(usr_a), .usr_b(usr_b), .usr_c(usr_c),
    .lut_en(lut_en), .lut_s(lut_s), .lut_a(lut_a), .lut_b(lut_b), .lut_c(lut_c),
    .lut_z(lut_z), .busy(busy), .done(done), .pass(pass), .mismatch(mismatch)
  );

  // Serial-load LUT: each enabled edge shifts S in at bit 0, so after eight
  // shifts the first bit sent sits in entry 7.
  always @(posedge clk) if (lut_en) lut_mem <= {lut_mem[6:0], lut_s};
  assign lut_z = lut_mem[{lut_a, lut_b, lut_c}] ^ fault[{lut_a, lut_b, lut_c}];

  always @(posedge clk) if (rst_n && cfg_valid && cfg_ready) acc_cnt <= acc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full load (and optional verify), checked cycle by cycle against the
  // timing and results derived from the table, verify flag and fault mask.
  // Entered and left at a sampling point just after a rising edge.
  task automatic run_op(input logic [7:0] data, input logic ven, input logic keep);
    int       w, acc0, done_t, en_n, sel_err, rdy_err, s_err;
    int       exp_done, hold, vend;
    logic [7:0] exp_mm;
    logic     exp_s;
    exp_done = ven ? 9 + 8 * (RD_LAT + 1) : 9;
    hold     = RD_LAT + 1;
    vend     = 8 + 8 * hold;
    exp_mm   = ven ? fault : 8'd0;
    cfg_data  = data;
    verify_en = ven;
    cfg_valid = 1'b1;
    w = 0;
    while (!cfg_ready && w < 100) begin @(posedge clk); #1; w++; end
    check("ready_wait", cfg_ready, 1);
    acc0 = acc_cnt;
    @(posedge clk); #1;
    tbl = data;
    if (!keep) cfg_valid = 1'b0;
    check("one_accept", acc_cnt, acc0 + 1);
    done_t = 0; en_n = 0; sel_err = 0; rdy_err = 0; s_err = 0;
    for (int t = 1; t <= 100 && done_t == 0; t++) begin
      if (t > 1) begin @(posedge clk); #1; end
      {usr_a, usr_b, usr_c} = 3'($urandom);
      #1;
      if (lut_en) en_n++;
      if (t <= 8) begin
        exp_s = (MSB_FIRST != 0) ? data[8 - t] : data[t - 1];
        if (lut_s !== exp_s || lut_en !== 1'b1) s_err++;
        if ({lut_a, lut_b, lut_c} !== 3'd0) sel_err++;
      end else if (ven && t <= vend) begin
        if ({lut_a, lut_b, lut_c} !== 3'((t - 9) / hold)) sel_err++;
      end
      if (cfg_ready !== 1'b0 || busy !== 1'b1) rdy_err++;
      if (done === 1'b1) done_t = t;
    end
    check("done_cycle", done_t, exp_done);
    check("en_cycles", en_n, 8);
    check("s_seq_err", s_err, 0);
    check("sel_err", sel_err, 0);
    check("busy_ready_err", rdy_err, 0);
    check("pass", pass, (exp_mm == 8'd0));
    check("mismatch", mismatch, exp_mm);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("ready_back", {cfg_ready, busy}, 2'b10);
    check("pass_held", {pass, mismatch}, {(exp_mm == 8'd0), exp_mm});
  endtask

  // IDLE pass-through: selects reach the LUT with no added cycles.
  task automatic sweep_idle(input logic maj);
    int err;
    logic exp_z;
    err = 0;
    for (int i = 0; i < 8; i++) begin
      {usr_a, usr_b, usr_c} = 3'(i);
      #1;
      if (maj) exp_z = ((i & 1) + ((i >> 1) & 1) + ((i >> 2) & 1)) >= 2;
      else     exp_z = tbl[i] ^ fault[i];
      if ({lut_a, lut_b, lut_c} !== 3'(i) || lut_z !== exp_z) err++;
    end
    check(maj ? "idle_majority" : "idle_passthru", err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = 8'd0; verify_en = 1'b0;
    usr_a = 1'b0; usr_b = 1'b0; usr_c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {lut_en, lut_s, done, pass, busy, cfg_ready}, 6'b000001);
    check("reset_mm", mismatch, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'hA5, 1'b0, 1'b0);
    run_op(8'h96, 1'b1, 1'b0);
    fault = 8'h08;
    run_op(8'hF0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("fail_held", {pass, mismatch}, {1'b0, 8'h08});
    fault = 8'h00;

    // cfg_valid held across two operations: one accept per return to IDLE.
    run_op(8'h3C, 1'b1, 1'b1);
    run_op(8'h3C, 1'b1, 1'b0);

    run_op(8'hE8, 1'b0, 1'b0);
    sweep_idle(1'b1);

    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 2))
        0:       fault = 8'h00;
        1:       fault = 8'(1 << $urandom_range(0, 7));
        default: fault = 8'($urandom);
      endcase
      run_op(8'($urandom), 1'($urandom), 1'b0);
      sweep_idle(1'b0);
    end
    fault = 8'h00;

    // Reset asynchronously in the middle of SHIFT (counter at 4).
    cfg_data = 8'h77; verify_en = 1'b1; cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("pre_reset_en", lut_en, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset", {lut_en, busy, pass, done, cfg_ready}, 5'b00001);
    check("async_reset_mm", mismatch, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h5A, 1'b1, 1'b0);
    sweep_idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
